serial_adder_ctrl: RTL and testbench

//  Bit-serial adder controller: sequences a single 1-bit full-adder slice over WIDTH

---
 rtl/serial_adder_ctrl.sv | 134 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one internal full-adder slice, LSB first, WIDTH cycles per add.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the `sub` port).
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("serial_adder_ctrl: WIDTH must be in 2..32");
    end

    state_e            state_q;
    logic [WIDTH-1:0]  opa_q;
    logic [WIDTH-1:0]  opb_q;
    logic [WIDTH-2:0]  psum_q;
    logic              carry_q;
    logic [CntW-1:0]   cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;

    logic              fa_s;
    logic              carry_d;
    logic [WIDTH-1:0]  sum_d;
    logic [WIDTH-2:0]  psum_d;
    logic              accept;
    logic [WIDTH-1:0]  opb_load;
    logic              carry_load;

    // Full-adder slice on the current LSBs.
    assign fa_s    = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign carry_d = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

    // New bit enters at the MSB; on the last cycle sum_d is the complete result.
    assign sum_d  = {fa_s, psum_q};
    assign psum_d = sum_d[WIDTH-1:1];

    assign accept = start && ((state_q == StIdle) || (state_q == StDone));

`ifdef SERIAL_ADDER_SUB_EN
    // a - b computed as a + ~b + 1; cout=1 means no borrow.
    assign opb_load   = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign opb_load   = b;
    assign carry_load = cin;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            psum_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        opa_q   <= a;
                        opb_q   <= opb_load;
                        carry_q <= carry_load;
                        psum_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StShift;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StShift: begin
                    opa_q   <= {1'b0, opa_q[WIDTH-1:1]};
                    opb_q   <= {1'b0, opb_q[WIDTH-1:1]};
                    carry_q <= carry_d;
                    psum_q  <= psum_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        sum_q   <= sum_d;
                        cout_q  <= carry_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

`ifndef SYNTHESIS
    a_busy_state: assert property (@(posedge clk) busy_q == (state_q == StShift));
    a_done_state: assert property (@(posedge clk) done_q |-> (state_q == StDone));
    a_cnt_range:  assert property (@(posedge clk) (state_q == StShift) |-> (cnt_q <= CntLast));
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: WIDTH=8 directed vectors plus a WIDTH=2 exhaustive sweep.
// Subtract vectors are included when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    typedef struct {
        logic [8:0]  res;
        int unsigned at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic        sub;
    logic        sub2;
`endif
    logic        busy;
    logic        done;
    logic [7:0]  sum;
    logic        cout;

    logic        start2;
    logic [1:0]  a2;
    logic [1:0]  b2;
    logic        cin2;
    logic        busy2;
    logic        done2;
    logic [1:0]  sum2;
    logic        cout2;

    int unsigned cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    exp_t        q8[$];
    exp_t        q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .cin   (cin2),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub2),
`endif
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .cout  (cout2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitors: pop one expectation per done pulse, compare result and completion cycle.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", {31'b0, done}, 32'd0);
            end else begin
                e = q8.pop_front();
                check("result8", {23'b0, cout, sum}, {23'b0, e.res});
                check("latency8", cyc, e.at);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (done2 === 1'b1) begin
            if (q2.size() == 0) begin
                check("unexpected_done2", {31'b0, done2}, 32'd0);
            end else begin
                e = q2.pop_front();
                check("result2", {29'b0, cout2, sum2}, {23'b0, e.res});
                check("latency2", cyc, e.at);
            end
        end
    end

    task automatic issue8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                          input logic tsub, input logic [8:0] res, input bit expect_done);
        a     = ta;
        b     = tb_v;
        cin   = tcin;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = tsub;
`endif
        start = 1'b1;
        if (expect_done) q8.push_back('{res, cyc + 1 + W});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        logic [2:0] r2;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        start2 = 1'b0;
        a2     = '0;
        b2     = '0;
        cin2   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub    = 1'b0;
        sub2   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_sum", {24'b0, sum}, 32'd0);
        check("rst_cout", {31'b0, cout}, 32'd0);
        check("rst_busy2", {31'b0, busy2}, 32'd0);

        // Start while busy is ignored; sum holds the prior (reset) value until completion.
        issue8(8'h01, 8'h02, 1'b0, 1'b0, 9'h003, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_sum", {24'b0, sum}, 32'd0);
            check("hold_busy", {31'b0, busy}, 32'd1);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("no_relaunch", {31'b0, busy}, 32'd0);

        // Basic add with busy window and one-cycle done pulse.
        issue8(8'h5A, 8'h3C, 1'b0, 1'b0, 9'h096, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("busy_window", {31'b0, busy}, 32'd1);
        end
        @(negedge clk);
        check("busy_after", {31'b0, busy}, 32'd0);
        @(negedge clk);
        check("done_pulse_width", {31'b0, done}, 32'd0);

        // Carry boundaries.
        issue8(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 1'b1);
        repeat (W + 2) @(posedge clk);
        issue8(8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, 1'b1);
        repeat (W + 2) @(posedge clk);

        // Start held high through DONE: back-to-back with no IDLE gap.
        #1;
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        q8.push_back('{9'h046, cyc + 1 + W});
        q8.push_back('{9'h101, cyc + 1 + 2 * W + 1});
        @(posedge clk);
        #1 a = 8'h80; b = 8'h80; cin = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("b2b_busy_last", {31'b0, busy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("b2b_busy_done", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("b2b_busy_second", {31'b0, busy}, 32'd1);
        repeat (W + 2) @(posedge clk);

        // Reset mid-operation aborts: outputs cleared, no done afterwards.
        #1;
        issue8(8'h33, 8'h44, 1'b0, 1'b0, 9'h000, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_sum", {24'b0, sum}, 32'd0);
        check("abort_cout", {31'b0, cout}, 32'd0);
        repeat (12) @(posedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        #1;
        issue8(8'h10, 8'h01, 1'b0, 1'b1, 9'h10F, 1'b1);
        repeat (W + 2) @(posedge clk);
        #1;
        issue8(8'h01, 8'h02, 1'b0, 1'b1, 9'h0FF, 1'b1);
        repeat (W + 2) @(posedge clk);
        #1;
        issue8(8'h10, 8'h01, 1'b1, 1'b1, 9'h10F, 1'b1);
        repeat (W + 2) @(posedge clk);
`endif

        // WIDTH=2 exhaustive sweep.
        for (int i = 0; i < 32; i++) begin
            #1;
            a2   = i[4:3];
            b2   = i[2:1];
            cin2 = i[0];
            r2   = {1'b0, a2} + {1'b0, b2} + {2'b0, cin2};
            q2.push_back('{{6'b0, r2}, cyc + 1 + 2});
            start2 = 1'b1;
            @(posedge clk);
            #1 start2 = 1'b0;
            repeat (3) @(posedge clk);
        end

        repeat (5) @(posedge clk);
        check("pending8", q8.size(), 32'd0);
        check("pending2", q2.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
